// File: rtl/mealy_fsm_pkg.sv
// Shared state encodings and move tables of the 6-state (a,b) symbol decoder.
// Used by the path driver and by the decoder's own bench.
package mealy_fsm_pkg;

  localparam logic [3:0] S0 = 4'd0;
  localparam logic [3:0] S1 = 4'd1;
  localparam logic [3:0] S2 = 4'd2;
  localparam logic [3:0] S3 = 4'd3;
  localparam logic [3:0] S4 = 4'd4;
  localparam logic [3:0] S5 = 4'd5;

  localparam logic [1:0] HOLD_S0 = 2'b00;
  localparam logic [1:0] HOLD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    GAP,
    DONE
  } mpd_state_t;

  function automatic logic [3:0] fsm_next(
    input logic [3:0] cur,
    input logic [1:0] ab
  );
    logic [3:0] n;
    n = cur;
    case (cur)
      S0: if (ab == 2'b11) n = S1;
          else if (ab == 2'b10) n = S5;
      S1: if (ab == 2'b10) n = S4;
          else if (ab == 2'b01) n = S3;
      S2: if (ab == 2'b00) n = S1;
          else if (ab == 2'b10) n = S5;
      S3: if (ab == 2'b00) n = S2;
          else if (ab == 2'b10) n = S4;
      S4: if (ab == 2'b10) n = S3;
          else if (ab == 2'b01) n = S5;
      S5: if (ab == 2'b00) n = S5;
          else if (ab == 2'b10) n = S1;
      default: n = cur;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] next_hop(
    input logic [3:0] cur,
    input logic [3:0] tgt
  );
    logic [1:0] s;
    s = HOLD;
    case (cur)
      S0: s = (tgt == S5) ? 2'b10 : 2'b11;
      S1: s = (tgt == S2 || tgt == S3) ? 2'b01 : 2'b10;
      S2: s = (tgt == S5) ? 2'b10 : 2'b00;
      S3: s = (tgt == S1 || tgt == S2) ? 2'b00 : 2'b10;
      S4: s = (tgt == S1 || tgt == S5) ? 2'b01 : 2'b10;
      S5: s = 2'b10;
      default: s = HOLD;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] hold_sym(input logic [3:0] cur);
    return (cur == S0) ? HOLD_S0 : HOLD;
  endfunction

endpackage

// File: rtl/mealy_path_driver_shadow.sv
// Shadow copy of the decoder state; advances only while a move symbol is on a/b.
module mealy_shadow
  import mealy_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [1:0] ab,
  output logic [3:0] cur_state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S0;
    end else if (step) begin
      cur_state <= fsm_next(cur_state, ab);
    end
  end

endmodule

// File: rtl/mealy_path_driver.sv
// Drives a/b symbols walking the decoder FSM to a requested state.
// Optional hop counter output enabled by MPD_HOPCNT_EN.
module mealy_path_driver
  import mealy_fsm_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] target,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       a,
  output logic       b,
  output logic [3:0] cur_state
`ifdef MPD_HOPCNT_EN
  ,
  output logic [1:0] hops
`endif
);

  localparam logic [2:0] GAP_LD =
    (IDLE_GAP == 0) ? 3'd0 : 3'(IDLE_GAP - 1);

  mpd_state_t state, state_d;
  logic [1:0] ab, ab_d;
  logic [3:0] tgt, tgt_d;
  logic [3:0] nxt;
  logic [2:0] gcnt, gcnt_d;
  logic       busy_d, done_d, err_d;
  logic       step;

  assign a = ab[1];
  assign b = ab[0];

  mealy_shadow u_shadow (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .ab        (ab),
    .cur_state (cur_state)
  );

  always_comb begin
    state_d = state;
    ab_d    = ab;
    tgt_d   = tgt;
    gcnt_d  = gcnt;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    step    = 1'b0;
    nxt     = fsm_next(cur_state, ab);
    unique case (state)
      IDLE: begin
        ab_d = hold_sym(cur_state);
        if (req) begin
          tgt_d = target;
          // S0 has no incoming edge from any other state
          if (target > S5 || (target == S0 && cur_state != S0)) begin
            err_d = 1'b1;
          end else if (target == cur_state) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = MOVE;
            busy_d  = 1'b1;
            ab_d    = next_hop(cur_state, target);
          end
        end
      end
      MOVE: begin
        step = 1'b1;
        if (nxt == tgt) begin
          state_d = DONE;
          done_d  = 1'b1;
          ab_d    = hold_sym(nxt);
        end else if (IDLE_GAP != 0) begin
          state_d = GAP;
          busy_d  = 1'b1;
          ab_d    = hold_sym(nxt);
          gcnt_d  = GAP_LD;
        end else begin
          busy_d = 1'b1;
          ab_d   = next_hop(nxt, tgt);
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gcnt == 3'd0) begin
          state_d = MOVE;
          ab_d    = next_hop(cur_state, tgt);
        end else begin
          gcnt_d = gcnt - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ab_d    = hold_sym(cur_state);
      end
      default: begin
        state_d = IDLE;
        ab_d    = hold_sym(cur_state);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ab    <= HOLD_S0;
      tgt   <= S0;
      gcnt  <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      ab    <= ab_d;
      tgt   <= tgt_d;
      gcnt  <= gcnt_d;
      busy  <= busy_d;
      done  <= done_d;
      err   <= err_d;
    end
  end

`ifdef MPD_HOPCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hops <= 2'd0;
    end else if (state == IDLE && state_d != IDLE) begin
      hops <= 2'd0;
    end else if (state == MOVE) begin
      hops <= hops + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mealy_path_driver.sv
// Directed scoreboard bench for mealy_path_driver (IDLE_GAP=0 and IDLE_GAP=2).
module tb_mealy_path_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req2 = 1'b0;
  logic [3:0] tgt0 = 4'd0, tgt2 = 4'd0;
  logic       busy0, done0, err0, a0, b0;
  logic       busy2, done2, err2, a2, b2;
  logic [3:0] cur0, cur2;
`ifdef MPD_HOPCNT_EN
  logic [1:0] hops0, hops2;
`endif

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [8:0] v;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mealy_path_driver #(.IDLE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .target(tgt0),
    .busy(busy0), .done(done0), .err(err0),
    .a(a0), .b(b0), .cur_state(cur0)
`ifdef MPD_HOPCNT_EN
    , .hops(hops0)
`endif
  );

  mealy_path_driver #(.IDLE_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .target(tgt2),
    .busy(busy2), .done(done2), .err(err2),
    .a(a2), .b(b2), .cur_state(cur2)
`ifdef MPD_HOPCNT_EN
    , .hops(hops2)
`endif
  );

  function automatic logic [8:0] obs(input int sel);
    if (sel == 0) return {a0, b0, busy0, done0, err0, cur0};
    return {a2, b2, busy2, done2, err2, cur2};
  endfunction

  // expected {ab, busy, done, err, cur}
  task automatic push(input string tag, input int sel,
                      input logic [1:0] ab, input logic bsy,
                      input logic dn, input logic er,
                      input logic [3:0] cur);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.v   = {ab, bsy, dn, er, cur};
    q.push_back(e);
  endtask

  task automatic cmp();
    exp_t e;
    logic [8:0] o;
    ncmp++;
    if (q.size() == 0) begin
      nerr++;
      $display("FAIL scoreboard_empty: observed none required entry");
    end else begin
      e = q.pop_front();
      o = obs(e.sel);
      assert (o === e.v) else begin
        nerr++;
        $error("FAIL %s: observed ab=%b bde=%b cur=%0d required ab=%b bde=%b cur=%0d",
               e.tag, o[8:7], o[6:4], o[3:0], e.v[8:7], e.v[6:4], e.v[3:0]);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cmp();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    push("rst0", 0, 2'b00, 0, 0, 0, 4'd0); cmp();
    push("rst2", 1, 2'b00, 0, 0, 0, 4'd0); cmp();
    @(posedge clk); #1; rst = 1'b1;

    // S0 -> S2, no gap
    req0 = 1'b1; tgt0 = 4'd2;
    push("t1_h1", 0, 2'b11, 1, 0, 0, 4'd0); cyc();
    req0 = 1'b0; tgt0 = 4'd9;
    push("t1_h2", 0, 2'b01, 1, 0, 0, 4'd1); cyc();
    push("t1_h3", 0, 2'b00, 1, 0, 0, 4'd3); cyc();
    push("t1_done", 0, 2'b11, 0, 1, 0, 4'd2); cyc();
    push("t1_idle", 0, 2'b11, 0, 0, 0, 4'd2); cyc();
`ifdef MPD_HOPCNT_EN
    ncmp++;
    assert (hops0 === 2'd3) else begin
      nerr++;
      $error("FAIL t1_hops: observed %0d required 3", hops0);
    end
`endif

    // target == current
    req0 = 1'b1; tgt0 = 4'd2;
    push("t2_done", 0, 2'b11, 0, 1, 0, 4'd2); cyc();
    req0 = 1'b0;
    push("t2_idle", 0, 2'b11, 0, 0, 0, 4'd2); cyc();

    // unreachable S0 and invalid 7
    req0 = 1'b1; tgt0 = 4'd0;
    push("t3_err_s0", 0, 2'b11, 0, 0, 1, 4'd2); cyc();
    req0 = 1'b0;
    push("t3_idle_a", 0, 2'b11, 0, 0, 0, 4'd2); cyc();
    req0 = 1'b1; tgt0 = 4'd7;
    push("t3_err_7", 0, 2'b11, 0, 0, 1, 4'd2); cyc();
    req0 = 1'b0;
    push("t3_idle_b", 0, 2'b11, 0, 0, 0, 4'd2); cyc();

    // S2 -> S5 one hop
    req0 = 1'b1; tgt0 = 4'd5;
    push("t6_h1", 0, 2'b10, 1, 0, 0, 4'd2); cyc();
    req0 = 1'b0;
    push("t6_done5", 0, 2'b11, 0, 1, 0, 4'd5); cyc();
    push("t6_idle5", 0, 2'b11, 0, 0, 0, 4'd5); cyc();

    // S5 -> S2 while req held through busy and done
    req0 = 1'b1; tgt0 = 4'd2;
    push("t6_m1", 0, 2'b10, 1, 0, 0, 4'd5); cyc();
    tgt0 = 4'd4;
    push("t6_m2", 0, 2'b01, 1, 0, 0, 4'd1); cyc();
    push("t6_m3", 0, 2'b00, 1, 0, 0, 4'd3); cyc();
    push("t6_done2", 0, 2'b11, 0, 1, 0, 4'd2); cyc();
    push("t6_ign", 0, 2'b11, 0, 0, 0, 4'd2); cyc();
    req0 = 1'b0;
    push("t6_noq", 0, 2'b11, 0, 0, 0, 4'd2); cyc();
`ifdef MPD_HOPCNT_EN
    ncmp++;
    assert (hops0 === 2'd3) else begin
      nerr++;
      $error("FAIL t6_hops: observed %0d required 3", hops0);
    end
`endif

    // gap build: S0 -> S2 on dut2
    req2 = 1'b1; tgt2 = 4'd2;
    push("g_a1", 1, 2'b11, 1, 0, 0, 4'd0); cyc();
    req2 = 1'b0;
    push("g_a2", 1, 2'b11, 1, 0, 0, 4'd1); cyc();
    push("g_a3", 1, 2'b11, 1, 0, 0, 4'd1); cyc();
    push("g_a4", 1, 2'b01, 1, 0, 0, 4'd1); cyc();
    push("g_a5", 1, 2'b11, 1, 0, 0, 4'd3); cyc();
    push("g_a6", 1, 2'b11, 1, 0, 0, 4'd3); cyc();
    push("g_a7", 1, 2'b00, 1, 0, 0, 4'd3); cyc();
    push("g_adone", 1, 2'b11, 0, 1, 0, 4'd2); cyc();
    push("g_aidle", 1, 2'b11, 0, 0, 0, 4'd2); cyc();

    // gap: S2 -> S4
    req2 = 1'b1; tgt2 = 4'd4;
    push("t4_00", 1, 2'b00, 1, 0, 0, 4'd2); cyc();
    req2 = 1'b0;
    push("t4_g1", 1, 2'b11, 1, 0, 0, 4'd1); cyc();
    push("t4_g2", 1, 2'b11, 1, 0, 0, 4'd1); cyc();
    push("t4_10", 1, 2'b10, 1, 0, 0, 4'd1); cyc();
    push("t4_done", 1, 2'b11, 0, 1, 0, 4'd4); cyc();
    push("t4_idle", 1, 2'b11, 0, 0, 0, 4'd4); cyc();
`ifdef MPD_HOPCNT_EN
    ncmp++;
    assert (hops2 === 2'd2) else begin
      nerr++;
      $error("FAIL t4_hops: observed %0d required 2", hops2);
    end
`endif

    // async reset mid-move
    rst = 1'b0; #2;
    push("t5_rst", 0, 2'b00, 0, 0, 0, 4'd0); cmp();
    @(posedge clk); #1; rst = 1'b1;
    req0 = 1'b1; tgt0 = 4'd2;
    push("t5_h1", 0, 2'b11, 1, 0, 0, 4'd0); cyc();
    req0 = 1'b0;
    push("t5_h2", 0, 2'b01, 1, 0, 0, 4'd1); cyc();
    #2; rst = 1'b0; #1;
    push("t5_abort", 0, 2'b00, 0, 0, 0, 4'd0); cmp();
`ifdef MPD_HOPCNT_EN
    ncmp++;
    assert (hops0 === 2'd0) else begin
      nerr++;
      $error("FAIL t5_hops: observed %0d required 0", hops0);
    end
`endif
    @(posedge clk); #1; rst = 1'b1;
    push("t5_idle", 0, 2'b00, 0, 0, 0, 4'd0); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
